// File: rtl/data_memory_lsu.sv
// data_memory_lsu: byte-addressed, word-organised data RAM behind a
// valid/ready request/response handshake. Supports RV32 load/store sizes,
// byte-lane writes, misalignment/range/size checking and a configurable
// number of wait states between acceptance and response.
module data_memory_lsu #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 1,
  parameter int INIT_PRESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_size,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  // First byte address beyond the RAM; one extra bit so the compare cannot wrap.
  localparam logic [ADDR_W:0] BYTE_LIMIT = (ADDR_W+1)'(64'(DEPTH_WORDS) * 64'd4);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [31:0] PRESET0 = (INIT_PRESET != 0) ? 32'h0000_0001 : 32'h0000_0000;
  localparam logic [31:0] PRESET1 = (INIT_PRESET != 0) ? 32'h0000_0010 : 32'h0000_0000;
  localparam logic [31:0] PRESET2 = (INIT_PRESET != 0) ? 32'h0000_0100 : 32'h0000_0000;
  localparam logic [31:0] PRESET3 = (INIT_PRESET != 0) ? 32'h0000_1000 : 32'h0000_0000;
  localparam logic [31:0] PRESET4 = (INIT_PRESET != 0) ? 32'h0001_0000 : 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Storage is deliberately outside reset: contents survive a reset.
  logic [31:0] mem [DEPTH_WORDS] = '{0: PRESET0, 1: PRESET1, 2: PRESET2,
                                     3: PRESET3, 4: PRESET4, default: 32'h0};

  state_t            state;
  state_t            state_next;
  logic [3:0]        cnt;
  logic [3:0]        cnt_next;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [2:0]        lat_size;
  logic [31:0]       lat_wdata;

  logic              op_we;
  logic [ADDR_W-1:0] op_addr;
  logic [2:0]        op_size;
  logic [31:0]       op_wdata;
  logic [IDX_W-1:0]  op_idx;
  logic [31:0]       op_word;
  logic              op_err;
  logic [31:0]       rdata_next;
  logic              commit;

  // Size code is illegal if reserved, or a zero-extending size on a store.
  function automatic logic size_bad(input logic we, input logic [2:0] size);
    logic bad;
    case (size)
      3'b000, 3'b001, 3'b010: bad = 1'b0;
      3'b100, 3'b101:         bad = we;
      default:                bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] lane);
    logic mis;
    case (size)
      3'b001, 3'b101: mis = lane[0];
      3'b010:         mis = (lane != 2'b00);
      default:        mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Little-endian extraction of a byte/half/word with sign or zero extension.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  size,
                                               input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'h0, b};
      3'b101:  r = {16'h0, h};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Merge right-aligned store data into the addressed lanes; other lanes kept.
  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] wdata,
                                              input logic [2:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] r;
    r = old;
    case (size)
      3'b000: r[{lane, 3'b000} +: 8] = wdata[7:0];
      3'b001: begin
        if (lane[1]) begin
          r[31:16] = wdata[15:0];
        end else begin
          r[15:0] = wdata[15:0];
        end
      end
      3'b010:  r = wdata;
      default: r = old;
    endcase
    return r;
  endfunction

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_RESP);

  // Next-state and wait-counter logic; commit marks the edge entering RESP.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (WAIT_STATES > 0) begin
            state_next = ST_WAIT;
            cnt_next   = WAIT_LOAD;
          end else begin
            state_next = ST_RESP;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_RESP;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 4'd0;
      end
    endcase
    commit = (state_next == ST_RESP) && (state != ST_RESP);
  end

  // Operand select: live inputs when committing straight from IDLE, else latched copy.
  always_comb begin
    op_we    = lat_we;
    op_addr  = lat_addr;
    op_size  = lat_size;
    op_wdata = lat_wdata;
    if (state == ST_IDLE) begin
      op_we    = req_we;
      op_addr  = req_addr;
      op_size  = req_size;
      op_wdata = req_wdata;
    end else begin
      op_we    = lat_we;
      op_addr  = lat_addr;
      op_size  = lat_size;
      op_wdata = lat_wdata;
    end
    op_idx  = op_addr[IDX_W+1:2];
    op_word = mem[op_idx];
    op_err  = ({1'b0, op_addr} >= BYTE_LIMIT) | size_bad(op_we, op_size)
            | misaligned(op_size, op_addr[1:0]);
    if (op_we || op_err) begin
      rdata_next = 32'h0;
    end else begin
      rdata_next = load_extract(op_word, op_size, op_addr[1:0]);
    end
  end

  // Control state, request capture and registered response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_size   <= 3'b000;
      lat_wdata  <= 32'h0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if ((state == ST_IDLE) && req_valid) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_size  <= req_size;
        lat_wdata <= req_wdata;
      end
      if (commit) begin
        resp_rdata <= rdata_next;
        resp_err   <= op_err;
      end
    end
  end

  // Byte-lane write on the commit edge of an error-free store.
  always_ff @(posedge clk) begin
    if (commit && op_we && !op_err) begin
      mem[op_idx] <= store_merge(op_word, op_wdata, op_size, op_addr[1:0]);
    end
  end

endmodule

// File: tb/tb_data_memory_lsu.sv
// Bench for data_memory_lsu: directed vector table, random traffic against a
// byte-array reference model, stall and reset-during-wait sequences.
module tb_data_memory_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [2:0]  req_size   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_memory_lsu #(.DEPTH_WORDS(1024), .ADDR_W(32), .WAIT_STATES(1), .INIT_PRESET(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_size(req_size[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

  data_memory_lsu #(.DEPTH_WORDS(1024), .ADDR_W(32), .WAIT_STATES(3), .INIT_PRESET(1)) u_dut3 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_size(req_size[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

  // Reference model of the WAIT_STATES=1 instance: plain byte array.
  logic [7:0] ref_mem [4096];

  function automatic void model_op(input logic we, input logic [2:0] size,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   output logic [31:0] rdata, output logic err);
    int nbytes;
    int unsigned a;
    logic [31:0] val;
    a = addr;
    rdata = 32'h0;
    err = 1'b0;
    case (size)
      3'd0: nbytes = 1;
      3'd1: nbytes = 2;
      3'd2: nbytes = 4;
      3'd4: begin nbytes = 1; if (we) err = 1'b1; end
      3'd5: begin nbytes = 2; if (we) err = 1'b1; end
      default: begin nbytes = 1; err = 1'b1; end
    endcase
    if (a >= 4096) err = 1'b1;
    if ((a % nbytes) != 0) err = 1'b1;
    if (err) return;
    if (we) begin
      for (int i = 0; i < nbytes; i++) ref_mem[a + i] = wdata[8*i +: 8];
    end else begin
      val = 32'h0;
      for (int i = 0; i < nbytes; i++) val[8*i +: 8] = ref_mem[a + i];
      if (size == 3'd0 && val[7])  val = val | 32'hFFFF_FF00;
      if (size == 3'd1 && val[15]) val = val | 32'hFFFF_0000;
      rdata = val;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request on instance d starting #1 after a rising edge; returns
  // response and the number of edges from the drive edge to resp_valid.
  task automatic do_req(input int d, input logic we, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    chk("req_ready before request", {31'h0, req_ready[d]}, 32'h1);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_size[d]  = size;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      req_valid[d] = 1'b0;
    end while (!resp_valid[d] && lat < 40);
    if (!resp_valid[d]) chk("response timeout", 32'h0, 32'h1);
    rdata = resp_rdata[d];
    err   = resp_err[d];
    @(posedge clk); #1;
    chk("resp_valid drops after handshake", {31'h0, resp_valid[d]}, 32'h0);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl [18];
  logic [2:0] size_pool [10] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};

  initial begin
    logic [31:0] rd, mrd, held;
    logic        er, mer;
    int          lat;
    logic        we;
    logic [2:0]  sz;
    logic [31:0] ad, wd;

    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    ref_mem[0] = 8'h01; ref_mem[4] = 8'h10; ref_mem[9] = 8'h01;
    ref_mem[13] = 8'h10; ref_mem[18] = 8'h01;

    tbl[0]  = '{1'b0, 3'b010, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 1'b0};
    tbl[1]  = '{1'b1, 3'b010, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    tbl[2]  = '{1'b1, 3'b000, 32'h0000_0009, 32'h0000_0055, 32'h0000_0000, 1'b0};
    tbl[3]  = '{1'b0, 3'b010, 32'h0000_0008, 32'h0000_0000, 32'hDEAD_55EF, 1'b0};
    tbl[4]  = '{1'b0, 3'b000, 32'h0000_0009, 32'h0000_0000, 32'h0000_0055, 1'b0};
    tbl[5]  = '{1'b0, 3'b100, 32'h0000_000B, 32'h0000_0000, 32'h0000_00DE, 1'b0};
    tbl[6]  = '{1'b0, 3'b000, 32'h0000_000B, 32'h0000_0000, 32'hFFFF_FFDE, 1'b0};
    tbl[7]  = '{1'b1, 3'b001, 32'h0000_0012, 32'h0000_8001, 32'h0000_0000, 1'b0};
    tbl[8]  = '{1'b0, 3'b001, 32'h0000_0012, 32'h0000_0000, 32'hFFFF_8001, 1'b0};
    tbl[9]  = '{1'b0, 3'b101, 32'h0000_0012, 32'h0000_0000, 32'h0000_8001, 1'b0};
    tbl[10] = '{1'b0, 3'b010, 32'h0000_0010, 32'h0000_0000, 32'h8001_0000, 1'b0};
    tbl[11] = '{1'b0, 3'b010, 32'h0000_0006, 32'h0000_0000, 32'h0000_0000, 1'b1};
    tbl[12] = '{1'b0, 3'b001, 32'h0000_0003, 32'h0000_0000, 32'h0000_0000, 1'b1};
    tbl[13] = '{1'b0, 3'b010, 32'h0000_1000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    tbl[14] = '{1'b1, 3'b100, 32'h0000_0004, 32'h0000_00FF, 32'h0000_0000, 1'b1};
    tbl[15] = '{1'b1, 3'b010, 32'h0000_0006, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    tbl[16] = '{1'b0, 3'b011, 32'h0000_0004, 32'h0000_0000, 32'h0000_0000, 1'b1};
    tbl[17] = '{1'b0, 3'b010, 32'h0000_0004, 32'h0000_0000, 32'h0000_0010, 1'b0};

    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'h0;
      req_size[d] = 3'b010; req_wdata[d] = 32'h0; resp_ready[d] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("reset req_ready", {31'h0, req_ready[0]}, 32'h1);
    chk("reset resp_valid", {31'h0, resp_valid[0]}, 32'h0);
    chk("reset resp_rdata", resp_rdata[0], 32'h0);
    chk("reset resp_err", {31'h0, resp_err[0]}, 32'h0);

    // Directed vectors.
    for (int i = 0; i < 18; i++) begin
      do_req(0, tbl[i].we, tbl[i].size, tbl[i].addr, tbl[i].wdata, rd, er, lat);
      model_op(tbl[i].we, tbl[i].size, tbl[i].addr, tbl[i].wdata, mrd, mer);
      chk($sformatf("vec%0d rdata", i), rd, tbl[i].exp_rdata);
      chk($sformatf("vec%0d err", i), {31'h0, er}, {31'h0, tbl[i].exp_err});
      chk($sformatf("vec%0d latency", i), lat, 32'd2);
    end

    // Random traffic against the reference model.
    for (int n = 0; n < 200; n++) begin
      we = ($urandom_range(0, 2) == 0);
      sz = size_pool[$urandom_range(0, 9)];
      if ($urandom_range(0, 15) == 0) ad = $urandom;
      else ad = $urandom_range(0, 63);
      wd = $urandom;
      model_op(we, sz, ad, wd, mrd, mer);
      do_req(0, we, sz, ad, wd, rd, er, lat);
      chk($sformatf("rand%0d we=%0d sz=%0d a=%08h rdata", n, we, sz, ad), rd, mrd);
      chk($sformatf("rand%0d err", n), {31'h0, er}, {31'h0, mer});
    end

    // Response stall: outputs stable, no new acceptance, IDLE one edge after release.
    model_op(1'b0, 3'b010, 32'h0, 32'h0, mrd, mer);
    resp_ready[0] = 1'b0;
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_size[0] = 3'b010; req_addr[0] = 32'h0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      req_valid[0] = 1'b0;
    end while (!resp_valid[0] && lat < 40);
    chk("stall resp arrives", {31'h0, resp_valid[0]}, 32'h1);
    held = resp_rdata[0];
    chk("stall rdata", held, mrd);
    req_valid[0] = 1'b1; req_addr[0] = 32'h4;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("stall resp_valid held", {31'h0, resp_valid[0]}, 32'h1);
      chk("stall rdata held", resp_rdata[0], mrd);
      chk("stall req_ready low", {31'h0, req_ready[0]}, 32'h0);
    end
    resp_ready[0] = 1'b1; req_valid[0] = 1'b0;
    @(posedge clk); #1;
    chk("release resp_valid", {31'h0, resp_valid[0]}, 32'h0);
    chk("release req_ready", {31'h0, req_ready[0]}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("no phantom response", {31'h0, resp_valid[0]}, 32'h0);
    end

    // Reset during WAIT on the WAIT_STATES=3 instance.
    do_req(1, 1'b0, 3'b010, 32'h4, 32'h0, rd, er, lat);
    chk("ws3 LW 0x4", rd, 32'h0000_0010);
    chk("ws3 latency", lat, 32'd4);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_size[1] = 3'b010;
    req_addr[1] = 32'h0; req_wdata[1] = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    chk("ws3 in wait", {31'h0, req_ready[1]}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("async reset resp_valid", {31'h0, resp_valid[1]}, 32'h0);
    chk("async reset resp_rdata", resp_rdata[1], 32'h0);
    chk("async reset resp_err", {31'h0, resp_err[1]}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post reset req_ready", {31'h0, req_ready[1]}, 32'h1);
    do_req(1, 1'b0, 3'b010, 32'h0, 32'h0, rd, er, lat);
    chk("store discarded by reset", rd, 32'h0000_0001);
    chk("store discarded err", {31'h0, er}, 32'h0);
    model_op(1'b0, 3'b010, 32'h8, 32'h0, mrd, mer);
    do_req(0, 1'b0, 3'b010, 32'h8, 32'h0, rd, er, lat);
    chk("memory kept across reset", rd, mrd);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
